// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage: extracts and extends the
// immediate, adds it to the PC, and queues {imm, target, illegal} in a small FIFO.
`timescale 1ns/1ps

module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_flush,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [31:0]     io_in_bits_inst,
    input  logic [2:0]      io_in_bits_immSrc,
    input  logic            io_in_bits_immSign,
    input  logic [XLEN-1:0] io_in_bits_pc,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [XLEN-1:0] io_out_bits_imm,
    output logic [XLEN-1:0] io_out_bits_target,
    output logic            io_out_bits_illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] SRC_I = 3'd0;
    localparam logic [2:0] SRC_S = 3'd1;
    localparam logic [2:0] SRC_B = 3'd2;
    localparam logic [2:0] SRC_U = 3'd3;
    localparam logic [2:0] SRC_J = 3'd4;
    localparam logic [2:0] SRC_Z = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic            w_msb;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic            w_illegal;
    logic            w_unused_opcode;
    entry_t          w_entry;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_not_full;

    // Every signed field has its MSB at inst[31]; Z never sign-extends.
    assign w_msb           = io_in_bits_immSign & io_in_bits_inst[31];
    assign w_unused_opcode = ^io_in_bits_inst[6:0];

    generate
        if (XLEN > 32) begin : g_u_wide
            assign w_imm_u = {{(XLEN-32){w_msb}}, io_in_bits_inst[31:12], 12'h000};
        end else begin : g_u_narrow
            assign w_imm_u = {io_in_bits_inst[31:12], 12'h000};
        end
    endgenerate

    // NOTE: defaults first so every path assigns every output -- no latches.
    always_comb begin
        w_imm     = '0;
        w_illegal = 1'b0;
        case (io_in_bits_immSrc)
            SRC_I:   w_imm = {{(XLEN-12){w_msb}}, io_in_bits_inst[31:20]};
            SRC_S:   w_imm = {{(XLEN-12){w_msb}}, io_in_bits_inst[31:25],
                              io_in_bits_inst[11:7]};
            SRC_B:   w_imm = {{(XLEN-13){w_msb}}, io_in_bits_inst[31], io_in_bits_inst[7],
                              io_in_bits_inst[30:25], io_in_bits_inst[11:8], 1'b0};
            SRC_U:   w_imm = w_imm_u;
            SRC_J:   w_imm = {{(XLEN-21){w_msb}}, io_in_bits_inst[31], io_in_bits_inst[19:12],
                              io_in_bits_inst[20], io_in_bits_inst[30:21], 1'b0};
            SRC_Z:   w_imm = {{(XLEN-5){1'b0}}, io_in_bits_inst[19:15]};
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_target = io_in_bits_pc + w_imm;
    assign w_entry  = '{imm: w_imm, target: w_target, illegal: w_illegal};

    assign io_in_ready  = r_not_full & ~io_flush & ~reset;
    assign io_out_valid = (r_count != '0) & ~io_flush & ~reset;

    assign w_push = io_in_valid & io_in_ready;
    assign w_pop  = io_out_valid & io_out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Ready is registered from the next count so io_out_ready never reaches io_in_ready.
    always_ff @(posedge clock) begin
        if (reset || io_flush) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_not_full <= 1'b1;
        end else begin
            r_count    <= w_count_nxt;
            r_not_full <= (w_count_nxt < DEPTH_C);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign io_out_bits_imm     = r_mem[r_rd_ptr].imm;
    assign io_out_bits_target  = r_mem[r_rd_ptr].target;
    assign io_out_bits_illegal = r_mem[r_rd_ptr].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one stimulus
// stream; results are checked against an arithmetic reference model.
`timescale 1ns/1ps

module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic        sgn;
        logic [63:0] pc;
    } req_t;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
    } res_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic        sgn;
        logic [63:0] pc;
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic        ill;
    } dir_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [2:0]  src;
    logic        sgn;
    logic [63:0] pc;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tgt32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64, tgt64;

    int   n_checks = 0;
    int   n_errors = 0;
    req_t q[$];
    req_t cur;

    logic        s_ready, s_valid, s_ready64, s_valid64, s_acc, s_deq;
    logic [31:0] s_imm32, s_tgt32;
    logic [63:0] s_imm64, s_tgt64;
    logic        s_ill32, s_ill64;
    int          s_qsize;

    always #5 clock = ~clock;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clock              (clock),
        .reset              (reset),
        .io_flush           (flush),
        .io_in_valid        (in_valid),
        .io_in_ready        (in_ready32),
        .io_in_bits_inst    (inst),
        .io_in_bits_immSrc  (src),
        .io_in_bits_immSign (sgn),
        .io_in_bits_pc      (pc[31:0]),
        .io_out_valid       (out_valid32),
        .io_out_ready       (out_ready),
        .io_out_bits_imm    (imm32),
        .io_out_bits_target (tgt32),
        .io_out_bits_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clock              (clock),
        .reset              (reset),
        .io_flush           (flush),
        .io_in_valid        (in_valid),
        .io_in_ready        (in_ready64),
        .io_in_bits_inst    (inst),
        .io_in_bits_immSrc  (src),
        .io_in_bits_immSign (sgn),
        .io_in_bits_pc      (pc),
        .io_out_valid       (out_valid64),
        .io_out_ready       (out_ready),
        .io_out_bits_imm    (imm64),
        .io_out_bits_target (tgt64),
        .io_out_bits_illegal(ill64)
    );

    // Reference: pick the field bits by shifting, then sign-extend by subtracting 2^width.
    function automatic res_t model(input req_t r, input int xlen);
        res_t            o;
        longint unsigned ins, field, mask;
        int              w;
        bit              use_sign;
        ins      = 64'(r.inst);
        mask     = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        use_sign = r.sgn;
        field    = 0;
        w        = 1;
        o.ill    = 1'b0;
        case (r.src)
            3'd0: begin field = (ins >> 20) & 64'hFFF; w = 12; end
            3'd1: begin field = (((ins >> 25) & 64'h7F) << 5) | ((ins >> 7) & 64'h1F); w = 12; end
            3'd2: begin
                field = (((ins >> 31) & 64'h1) << 12) | (((ins >> 7) & 64'h1) << 11)
                      | (((ins >> 25) & 64'h3F) << 5) | (((ins >> 8) & 64'hF) << 1);
                w = 13;
            end
            3'd3: begin field = ins & 64'hFFFF_F000; w = 32; end
            3'd4: begin
                field = (((ins >> 31) & 64'h1) << 20) | (ins & 64'hF_F000)
                      | (((ins >> 20) & 64'h1) << 11) | (((ins >> 21) & 64'h3FF) << 1);
                w = 21;
            end
            3'd5: begin field = (ins >> 15) & 64'h1F; w = 5; use_sign = 1'b0; end
            default: o.ill = 1'b1;
        endcase
        if (use_sign && !o.ill && (((field >> (w - 1)) & 64'h1) != 0))
            field = field - (64'd1 << w);
        o.imm = field & mask;
        o.tgt = (r.pc + o.imm) & mask;
        return o;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.inst = $urandom;
        r.src  = 3'($urandom_range(0, 7));
        r.sgn  = 1'($urandom_range(0, 1));
        r.pc   = {$urandom, $urandom};
        return r;
    endfunction

    task automatic set_req(input req_t r);
        cur  = r;
        inst = r.inst;
        src  = r.src;
        sgn  = r.sgn;
        pc   = r.pc;
    endtask

    // One clock: sample everything at the falling edge, record accepted requests.
    task automatic step();
        @(negedge clock);
        s_ready   = in_ready32;
        s_valid   = out_valid32;
        s_ready64 = in_ready64;
        s_valid64 = out_valid64;
        s_acc     = in_valid && in_ready32;
        s_deq     = out_valid32 && out_ready;
        s_imm32   = imm32;
        s_tgt32   = tgt32;
        s_ill32   = ill32;
        s_imm64   = imm64;
        s_tgt64   = tgt64;
        s_ill64   = ill64;
        s_qsize   = q.size();
        if (s_acc) q.push_back(cur);
        @(posedge clock);
        #1;
    endtask

    task automatic pop_exp(output res_t e32, output res_t e64, output bit ok);
        req_t r;
        ok = 1'b0;
        if (s_qsize != 0 && q.size() != 0) begin
            r   = q.pop_front();
            e32 = model(r, 32);
            e64 = model(r, 64);
            ok  = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        set_req(rand_req());
        step();
        n_checks++;
        if ({s_ready, s_valid, s_ready64, s_valid64} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_hold: ready32/valid32/ready64/valid64 got %b%b%b%b want 0000",
                     s_ready, s_valid, s_ready64, s_valid64);
        end
        step();
        reset = 1'b0; in_valid = 1'b0;
        q.delete();
        step();
        n_checks++;
        if ({s_ready, s_valid, s_ready64, s_valid64} !== 4'b1010) begin
            n_errors++;
            $display("FAIL reset_release: ready32/valid32/ready64/valid64 got %b%b%b%b want 1010",
                     s_ready, s_valid, s_ready64, s_valid64);
        end
    endtask

    task automatic test_directed();
        dir_t dv[10];
        req_t r;
        dv[0] = '{32'hFFF00093, 3'd0, 1'b1, 64'h1000, 32'hFFFFFFFF, 32'h00000FFF,
                  64'hFFFFFFFF_FFFFFFFF, 64'h0FFF, 1'b0};
        dv[1] = '{32'hFFF00093, 3'd0, 1'b0, 64'h1000, 32'h00000FFF, 32'h00001FFF,
                  64'h0FFF, 64'h1FFF, 1'b0};
        dv[2] = '{32'hFE000CE3, 3'd2, 1'b1, 64'h100, 32'hFFFFFFF8, 32'h000000F8,
                  64'hFFFFFFFF_FFFFFFF8, 64'hF8, 1'b0};
        dv[3] = '{32'h800000B7, 3'd3, 1'b1, 64'h2000, 32'h80000000, 32'h80002000,
                  64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80002000, 1'b0};
        dv[4] = '{32'h800000B7, 3'd3, 1'b0, 64'h2000, 32'h80000000, 32'h80002000,
                  64'h00000000_80000000, 64'h00000000_80002000, 1'b0};
        dv[5] = '{32'h000F9073, 3'd5, 1'b1, 64'h40, 32'h1F, 32'h5F, 64'h1F, 64'h5F, 1'b0};
        dv[6] = '{32'h000F9073, 3'd7, 1'b1, 64'h40, 32'h0, 32'h40, 64'h0, 64'h40, 1'b1};
        dv[7] = '{32'hFFF00093, 3'd0, 1'b1, 64'hFFFFFFFF_FFFFFFF0, 32'hFFFFFFFF, 32'hFFFFFFEF,
                  64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFEF, 1'b0};
        dv[8] = '{32'h0100006F, 3'd4, 1'b1, 64'h1000, 32'h10, 32'h1010, 64'h10, 64'h1010, 1'b0};
        dv[9] = '{32'hFE112E23, 3'd1, 1'b1, 64'h1000, 32'hFFFFFFFC, 32'h00000FFC,
                  64'hFFFFFFFF_FFFFFFFC, 64'hFFC, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            r.inst = dv[i].inst; r.src = dv[i].src; r.sgn = dv[i].sgn; r.pc = dv[i].pc;
            set_req(r);
            in_valid = 1'b1;
            step();
            n_checks++;
            if ({s_acc, s_valid} !== 2'b10) begin
                n_errors++;
                $display("FAIL dir%0d_accept: acc/valid got %b%b want 10", i, s_acc, s_valid);
            end
            in_valid = 1'b0;
            step();
            n_checks++;
            if ({s_valid, s_valid64, s_imm32, s_tgt32, s_ill32} !==
                {2'b11, dv[i].imm32, dv[i].tgt32, dv[i].ill}) begin
                n_errors++;
                $display("FAIL dir%0d_x32: valid=%b imm=%h tgt=%h ill=%b want valid=1 imm=%h tgt=%h ill=%b",
                         i, s_valid, s_imm32, s_tgt32, s_ill32, dv[i].imm32, dv[i].tgt32, dv[i].ill);
            end
            n_checks++;
            if ({s_imm64, s_tgt64, s_ill64} !== {dv[i].imm64, dv[i].tgt64, dv[i].ill}) begin
                n_errors++;
                $display("FAIL dir%0d_x64: imm=%h tgt=%h ill=%b want imm=%h tgt=%h ill=%b",
                         i, s_imm64, s_tgt64, s_ill64, dv[i].imm64, dv[i].tgt64, dv[i].ill);
            end
        end
        q.delete();
    endtask

    task automatic test_back_pressure();
        res_t        e32, e64;
        bit          ok;
        int          accepted;
        logic [31:0] h_imm32, h_tgt32;
        logic [63:0] h_imm64;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(rand_req());
        accepted = 0;
        h_imm32 = '0; h_tgt32 = '0; h_imm64 = '0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_acc) begin
                accepted++;
                set_req(rand_req());
            end
            if (c == 1) begin
                h_imm32 = s_imm32; h_tgt32 = s_tgt32; h_imm64 = s_imm64;
            end
            if (c >= 2) begin
                n_checks++;
                if ({s_ready, s_ready64, s_valid} !== 3'b001) begin
                    n_errors++;
                    $display("FAIL bp_full_c%0d: ready32/ready64/valid got %b%b%b want 001",
                             c, s_ready, s_ready64, s_valid);
                end
                n_checks++;
                if ({s_imm32, s_tgt32, s_imm64} !== {h_imm32, h_tgt32, h_imm64}) begin
                    n_errors++;
                    $display("FAIL bp_head_stable_c%0d: imm32=%h tgt32=%h imm64=%h want %h %h %h",
                             c, s_imm32, s_tgt32, s_imm64, h_imm32, h_tgt32, h_imm64);
                end
            end
        end
        n_checks++;
        if (accepted != 2) begin
            n_errors++;
            $display("FAIL bp_accept_count: got %0d want 2", accepted);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({s_deq, s_ready} !== ((c == 0) ? 2'b10 : (c == 1) ? 2'b11 : 2'b01)) begin
                n_errors++;
                $display("FAIL bp_drain_c%0d: deq/ready got %b%b want %b",
                         c, s_deq, s_ready, ((c == 0) ? 2'b10 : (c == 1) ? 2'b11 : 2'b01));
            end
            if (s_deq) begin
                pop_exp(e32, e64, ok);
                n_checks++;
                if (!ok || {s_imm32, s_tgt32, s_ill32, s_imm64, s_tgt64, s_ill64} !==
                           {e32.imm[31:0], e32.tgt[31:0], e32.ill, e64.imm, e64.tgt, e64.ill}) begin
                    n_errors++;
                    $display("FAIL bp_drain_order_c%0d: got imm32=%h tgt32=%h imm64=%h want imm32=%h tgt32=%h imm64=%h",
                             c, s_imm32, s_tgt32, s_imm64, e32.imm[31:0], e32.tgt[31:0], e64.imm);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t e32, e64;
        bit   ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_req(rand_req());
        for (int c = 0; c < 17; c++) begin
            if (c == 16) in_valid = 1'b0;
            step();
            if (s_acc) set_req(rand_req());
            n_checks++;
            if ({s_acc, s_deq} !== {(c < 16), (c > 0)}) begin
                n_errors++;
                $display("FAIL b2b_rate_c%0d: acc/deq got %b%b want %b%b",
                         c, s_acc, s_deq, (c < 16), (c > 0));
            end
            if (s_deq) begin
                pop_exp(e32, e64, ok);
                n_checks++;
                if (!ok || {s_imm32, s_tgt32, s_ill32, s_imm64, s_tgt64, s_ill64} !==
                           {e32.imm[31:0], e32.tgt[31:0], e32.ill, e64.imm, e64.tgt, e64.ill}) begin
                    n_errors++;
                    $display("FAIL b2b_data_c%0d: got imm32=%h tgt32=%h imm64=%h tgt64=%h want %h %h %h %h",
                             c, s_imm32, s_tgt32, s_imm64, s_tgt64,
                             e32.imm[31:0], e32.tgt[31:0], e64.imm, e64.tgt);
                end
            end
        end
        q.delete();
    endtask

    task automatic test_flush();
        res_t e32, e64;
        bit   ok;
        int   accepted;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(rand_req());
        accepted = 0;
        for (int c = 0; c < 8 && accepted < 2; c++) begin
            step();
            if (s_acc) begin
                accepted++;
                set_req(rand_req());
            end
        end
        n_checks++;
        if (accepted != 2) begin
            n_errors++;
            $display("FAIL flush_fill: accepted %0d want 2", accepted);
        end
        flush = 1'b1; out_ready = 1'b1;
        step();
        n_checks++;
        if ({s_ready, s_valid, s_ready64, s_valid64, s_acc, s_deq} !== 6'b0) begin
            n_errors++;
            $display("FAIL flush_cycle: ready/valid/ready64/valid64/acc/deq got %b%b%b%b%b%b want 000000",
                     s_ready, s_valid, s_ready64, s_valid64, s_acc, s_deq);
        end
        flush = 1'b0;
        q.delete();
        set_req(rand_req());
        step();
        n_checks++;
        if ({s_valid, s_ready, s_acc} !== 3'b011) begin
            n_errors++;
            $display("FAIL flush_after: valid/ready/acc got %b%b%b want 011", s_valid, s_ready, s_acc);
        end
        in_valid = 1'b0;
        step();
        pop_exp(e32, e64, ok);
        n_checks++;
        if (!ok || !s_valid || {s_imm32, s_tgt32, s_ill32, s_imm64, s_tgt64, s_ill64} !==
                               {e32.imm[31:0], e32.tgt[31:0], e32.ill, e64.imm, e64.tgt, e64.ill}) begin
            n_errors++;
            $display("FAIL flush_new_req: valid=%b imm32=%h tgt32=%h imm64=%h want valid=1 %h %h %h",
                     s_valid, s_imm32, s_tgt32, s_imm64, e32.imm[31:0], e32.tgt[31:0], e64.imm);
        end
        step();
        n_checks++;
        if (s_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_alone: valid got %b want 0", s_valid);
        end
        // Reset with one entry buffered.
        out_ready = 1'b0; in_valid = 1'b1;
        set_req(rand_req());
        step();
        in_valid = 1'b0; reset = 1'b1;
        step();
        n_checks++;
        if ({s_valid, s_ready, s_valid64} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_mid_hold: valid/ready/valid64 got %b%b%b want 000",
                     s_valid, s_ready, s_valid64);
        end
        reset = 1'b0; out_ready = 1'b1;
        q.delete();
        step();
        n_checks++;
        if ({s_valid, s_ready, s_valid64} !== 3'b010) begin
            n_errors++;
            $display("FAIL reset_mid_after: valid/ready/valid64 got %b%b%b want 010",
                     s_valid, s_ready, s_valid64);
        end
    endtask

    task automatic test_random();
        res_t e32, e64;
        bit   ok;
        bit   exp_nf;
        exp_nf = 1'b1;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 32) == 0;
            set_req(rand_req());
            step();
            n_checks++;
            if ({s_ready, s_valid, s_ready64, s_valid64} !==
                {exp_nf && !flush, (s_qsize != 0) && !flush, exp_nf && !flush, (s_qsize != 0) && !flush}) begin
                n_errors++;
                $display("FAIL rand_hs_c%0d: ready/valid/ready64/valid64 got %b%b%b%b want %b%b",
                         c, s_ready, s_valid, s_ready64, s_valid64, exp_nf && !flush, (s_qsize != 0) && !flush);
            end
            if (s_deq) begin
                pop_exp(e32, e64, ok);
                n_checks++;
                if (!ok || {s_imm32, s_tgt32, s_ill32, s_imm64, s_tgt64, s_ill64} !==
                           {e32.imm[31:0], e32.tgt[31:0], e32.ill, e64.imm, e64.tgt, e64.ill}) begin
                    n_errors++;
                    $display("FAIL rand_data_c%0d: got imm32=%h tgt32=%h ill32=%b imm64=%h tgt64=%h want %h %h %b %h %h",
                             c, s_imm32, s_tgt32, s_ill32, s_imm64, s_tgt64,
                             e32.imm[31:0], e32.tgt[31:0], e32.ill, e64.imm, e64.tgt);
                end
            end
            if (flush) begin
                q.delete();
                exp_nf = 1'b1;
            end else begin
                exp_nf = (q.size() < 2);
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; src = '0; sgn = 1'b0; pc = '0;
        test_reset();
        test_directed();
        test_back_pressure();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage. It is the successor of the combinational immediate unit and is parametrised for RV32/RV64. It also computes the PC-relative target (pc + imm) and flags illegal immediate selects. A 2-entry output buffer gives full throughput under back-pressure and supports pipeline flush.

Parameters:
XLEN, 32, datapath width of imm/pc/target; legal values 32 or 64.
DEPTH, 2, output buffer entries; fixed power of two ≥2.

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
io_flush  input  1  drop all buffered entries and any same-cycle input
io_in_valid  input  1  request valid
io_in_ready  output  1  unit can accept request
io_in_bits_inst  input  32  raw instruction
io_in_bits_immSrc  input  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR uimm), 6/7 illegal
io_in_bits_immSign  input  1  1 sign-extend, 0 zero-extend
io_in_bits_pc  input  XLEN  instruction PC
io_out_valid  output  1  result valid
io_out_ready  input  1  consumer accepts result
io_out_bits_imm  output  XLEN  extended immediate
io_out_bits_target  output  XLEN  pc + imm, modulo 2^XLEN
io_out_bits_illegal  output  1  immSrc was 6 or 7

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, on port `reset`, sampled on rising `clock`.
- Reset state: buffer count=0 and all pointers 0. io_out_valid=0 and io_in_ready=0 while reset is high. io_in_ready=1 from the first cycle after reset deasserts. Buffered data bits are don't-care under reset; io_out_bits_* are only meaningful when valid.
- Field extraction (bit positions are fixed for every XLEN):
  - I = inst[31:20] (12 b)
  - S = {inst[31:25], inst[11:7]} (12 b)
  - B = {inst[31], inst[7], inst[30:25], inst[11:8], 0} (13 b)
  - J = {inst[31], inst[19:12], inst[20], inst[30:21], 0} (21 b)
  - U = {inst[31:12], 12'h0} (32 b)
  - Z = inst[19:15] (5 b)
- Extension rules:
  - immSign=1: replicate the field MSB up to XLEN. U with XLEN=64 replicates inst[31].
  - immSign=0: zero-extend.
  - Z is always zero-extended, regardless of immSign.
  - immSrc 6/7: imm=0, target=pc, illegal=1. In all other cases illegal=0.
- target = pc + imm, XLEN-bit add, carry discarded. It is always computed, even for I/S/Z.
- Latency: an input accepted in cycle N (io_in_valid & io_in_ready) is visible on io_out_* in cycle N+1 at the earliest. There is no combinational path from in to out, and no combinational path from io_out_ready to io_in_ready.
- Buffer:
  - FIFO of DEPTH entries holding {imm, target, illegal}, computed before the write.
  - io_in_ready = registered (count < DEPTH) & ~io_flush.
  - io_out_valid = (count != 0) & ~io_flush.
  - The output shows the head entry. Head bits stay stable while io_out_valid=1 and io_out_ready=0.
  - Enqueue and dequeue in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
  - Full (count=DEPTH): io_in_ready=0 in the following cycle. A dequeue while full frees a slot, and io_in_ready=1 the next cycle.
  - Empty: io_out_valid=0, and io_out_ready is ignored.
- Flush: when io_flush=1, in_ready=0 and out_valid=0 in that cycle, so no handshake can occur on either side. Next cycle: count=0, pointers 0. Flush and reset together behave as reset.
- Reset mid-operation: all buffered entries are lost. No output handshake occurs in the reset cycle.

Test Plan:
- XLEN=32, inst=0xFFF00093, immSrc=0, pc=0x1000. With immSign=1 → imm=0xFFFFFFFF, target=0x00000FFF. With immSign=0 → imm=0x00000FFF, target=0x00001FFF. Each result appears 1 cycle after acceptance.
- XLEN=32, inst=0xFE000CE3, immSrc=2, immSign=1, pc=0x100 → imm=0xFFFFFFF8, target=0x000000F8, illegal=0.
- XLEN=64, inst=0x800000B7, immSrc=3. With immSign=1 → imm=0xFFFFFFFF80000000. With immSign=0 → imm=0x0000000080000000.
- inst=0x000F9073 (CSR uimm=31), immSrc=5, immSign=1 → imm=0x1F. The same inst with immSrc=7 → imm=0, target=pc, illegal=1.
- Back-pressure, continuous input, io_out_ready=0:
  - Exactly 2 requests are accepted, then io_in_ready=0.
  - Raising io_out_ready drains them in order, with head bits stable while stalled.
  - Then throughput is 1 per cycle with ready held high.
- Flush: fill 2 entries, assert io_flush one cycle alongside a valid input → no handshake in that cycle. Next cycle io_out_valid=0 and io_in_ready=1; a new request appears alone after 1 cycle. Reset asserted with 1 entry buffered → io_out_valid=0 after reset.
